rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-side front end of the 32x32 register file. Merges two result producers onto the single register-file write port (rf_wr / wr_reg / wr_data):
  - the in-order pipeline writeback (source A, never stalls);
  - late results from the multi-cycle mul/div and load path (source B, valid/ready).
- Source B results are buffered in a small FIFO.
- Exposes a pending-destination query for issue hazard checks, and a stall request when B is starved.

Parameters:
- DEPTH, 4, source-B FIFO entries; power of two, >=2.
- STARVE_LIMIT, 8, consecutive cycles B is blocked by A before stall_req asserts; >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline writeback valid.
- a_reg  in  5  pipeline destination register.
- a_data  in  32  pipeline result.
- b_valid  in  1  late result valid.
- b_ready  out  1  FIFO can accept; equals !full.
- b_reg  in  5  late destination register.
- b_data  in  32  late result.
- rf_wr  out  1  register-file write enable (registered).
- wr_reg  out  5  register-file write address (registered).
- wr_data  out  32  register-file write data (registered).
- q_reg  in  5  query register index.
- q_pending  out  1  combinational; a B write to q_reg is queued or in the output register.
- stall_req  out  1  registered; asks upstream to insert a bubble on A.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock edge with rst=1 gives:
  - rf_wr=0, wr_reg=0, wr_data=0;
  - FIFO empty, rd/wr pointers=0, fifo_count=0;
  - starve counter=0, stall_req=0.
  - b_ready=0 while rst=1. It is 1 on the first cycle after rst falls.
- Reset mid-operation: all queued B entries are discarded. No rf_wr pulse is produced for them.
- Enqueue:
  - b_valid & b_ready pushes {b_reg, b_data}.
  - An entry with b_reg==0 is accepted (handshake completes) but not stored; fifo_count is unchanged.
- b_ready:
  - Derived from the registered count, so a full FIFO refuses a push even if a pop occurs the same cycle.
  - b_valid while b_ready=0 is ignored; the source holds it.
- Arbitration, once per cycle, with the result registered on the next edge (latency 1):
  - If a_valid & a_reg!=0: write A. The output register gets {1, a_reg, a_data}.
  - Else if the FIFO is non-empty: pop the head. The output register gets {1, head_reg, head_data}.
  - Else: rf_wr=0, and wr_reg/wr_data hold their previous values.
  - a_valid with a_reg==0 counts as no A request; the FIFO may drain that cycle.
- Simultaneous push and pop (not full):
  - Both occur.
  - Count is unchanged.
  - A push into an empty FIFO is not poppable in the same cycle (no bypass).
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and A wins; saturates at STARVE_LIMIT.
  - Clears on any cycle a pop occurs or the FIFO is empty.
- stall_req:
  - Registered; high on the cycle after the counter equals STARVE_LIMIT.
  - Stays high until the next pop.
  - While stall_req=1, A still has priority if a_valid=1; data is never dropped.
- q_pending is 1 when q_reg!=0 and either:
  - any valid FIFO entry has reg==q_reg; or
  - the output register holds a B-sourced write with wr_reg==q_reg and rf_wr=1.
- Ordering (WAW between A and queued B) is the issue logic's responsibility via q_pending. The arbiter does not reorder or cancel writes.

Test Plan:
- Reset, then an A burst of a_reg=5, data 0x11, 0x22 on consecutive cycles -> rf_wr=1, wr_reg=5, wr_data=0x11 then 0x22, each one cycle after input; b_ready=1, fifo_count=0.
- Push B {7, 0xDEAD_BEEF} with A idle -> fifo_count=1 next cycle; pop the following cycle -> rf_wr=1, wr_reg=7, wr_data=0xDEADBEEF; q_pending(q_reg=7)=1 from push until the cycle after the write is presented.
- Hold a_valid=1 (a_reg=3) continuously and push 4 B entries -> b_ready=0 after the 4th, fifo_count=4; stall_req rises STARVE_LIMIT+1 cycles after the first blocked cycle. Drop a_valid -> entries drain in order, one per cycle; stall_req clears after the first pop.
- Push B with b_reg=0 and drive a_valid with a_reg=0 -> no rf_wr pulse, fifo_count stays 0, b_ready stays 1.
- Full FIFO, pop and b_valid in the same cycle -> push refused (b_ready=0); count goes 4->3; pointer wrap verified by 3*DEPTH push/pop cycles with incrementing data and no loss.
- Assert rst for one cycle with fifo_count=3 -> next cycle fifo_count=0, rf_wr=0, stall_req=0, q_pending=0 for all q_reg; no stale writes after reset.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the writeback producers, the register-file write port
// and the issue-side hazard query of rf_wb_arbiter.
interface rf_wb_arbiter_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic [4:0]    a_reg;
    logic [31:0]   a_data;
    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_reg;
    logic [31:0]   b_data;
    logic          rf_wr;
    logic [4:0]    wr_reg;
    logic [31:0]   wr_data;
    logic [4:0]    q_reg;
    logic          q_pending;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, q_reg,
        input  b_ready, rf_wr, wr_reg, wr_data, q_pending, stall_req, fifo_count
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, q_reg,
        output b_ready, rf_wr, wr_reg, wr_data, q_pending, stall_req, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: in-order writeback (A) has priority,
// late mul/div/load results (B) are queued and drained when A is idle.
module rf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic          stall_q;
    logic          rf_wr_q, out_b;
    logic [4:0]    wr_reg_q;
    logic [31:0]   wr_data_q;

    logic a_req, empty, push, store, pop;

    always_comb begin
        a_req = bus.a_valid && (bus.a_reg != 5'd0);
        empty = (count == '0);
        push  = bus.b_valid && bus.b_ready;
        // Writes to r0 complete the handshake but never occupy a slot.
        store = push && (bus.b_reg != 5'd0);
        // Pop decision uses the registered count, so a same-cycle push is never bypassed.
        pop   = !a_req && !empty;
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= '{r: bus.b_reg, d: bus.b_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            stall_q   <= 1'b0;
            rf_wr_q   <= 1'b0;
            out_b     <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(store) - CW'(pop);

            if (a_req) begin
                rf_wr_q   <= 1'b1;
                out_b     <= 1'b0;
                wr_reg_q  <= bus.a_reg;
                wr_data_q <= bus.a_data;
            end else if (pop) begin
                rf_wr_q   <= 1'b1;
                out_b     <= 1'b1;
                wr_reg_q  <= mem[rd_ptr].r;
                wr_data_q <= mem[rd_ptr].d;
            end else begin
                rf_wr_q <= 1'b0;
                out_b   <= 1'b0;
            end

            // Non-empty without a pop means A took the port this cycle.
            if (pop || empty)      starve <= '0;
            else if (starve != LIMIT) starve <= starve + 1'b1;

            if (pop)                  stall_q <= 1'b0;
            else if (starve == LIMIT) stall_q <= 1'b1;
        end
    end

    logic [DEPTH-1:0] ent_hit;
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [AW-1:0] off;
        assign off        = AW'(i) - rd_ptr;
        assign ent_hit[i] = ({1'b0, off} < count) && (mem[i].r == bus.q_reg);
    end

    assign bus.q_pending  = (bus.q_reg != 5'd0) &&
                            ((|ent_hit) || (rf_wr_q && out_b && (wr_reg_q == bus.q_reg)));
    assign bus.b_ready    = !rst && (count != CW'(DEPTH));
    assign bus.fifo_count = count;
    assign bus.rf_wr      = rf_wr_q;
    assign bus.wr_reg     = wr_reg_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.stall_req  = stall_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int CW           = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    ent_t        mq[$];
    logic        m_wr    = 1'b0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;
    bit          m_out_b = 1'b0;
    int          m_starve = 0;
    bit          m_stall = 1'b0;

    function automatic logic m_b_ready();
        return !rst && (mq.size() < DEPTH);
    endfunction

    function automatic logic m_q_pending(logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == q) return 1'b1;
        return m_wr && m_out_b && (m_reg == q);
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic cycle();
        bit   a_req, pop, push, was_empty;
        ent_t head;
        if (rst) begin
            mq.delete();
            m_wr = 0; m_reg = '0; m_data = '0; m_out_b = 0; m_starve = 0; m_stall = 0;
        end else begin
            a_req     = bus.a_valid && (bus.a_reg != 0);
            push      = bus.b_valid && (mq.size() < DEPTH);
            was_empty = (mq.size() == 0);
            pop       = !a_req && !was_empty;
            if (a_req) begin
                m_wr = 1; m_reg = bus.a_reg; m_data = bus.a_data; m_out_b = 0;
            end else if (pop) begin
                head = mq.pop_front();
                m_wr = 1; m_reg = head.r; m_data = head.d; m_out_b = 1;
            end else begin
                m_wr = 0; m_out_b = 0;
            end
            if (pop) m_stall = 0;
            else if (m_starve == STARVE_LIMIT) m_stall = 1;
            if (pop || was_empty) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
            if (push && bus.b_reg != 0) mq.push_back('{r: bus.b_reg, d: bus.b_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 0; bus.b_reg = '0; bus.b_data = '0;
        bus.q_reg   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cycle();
        n_tests++; if (bus.rf_wr !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wr got=%b exp=0", bus.rf_wr); end
        n_tests++; if (bus.wr_reg !== 5'd0) begin n_fail++; $display("FAIL reset_wr_reg got=%0d exp=0", bus.wr_reg); end
        n_tests++; if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
        n_tests++; if (bus.fifo_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
        n_tests++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
        n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready_in_rst got=%b exp=0", bus.b_ready); end
        rst = 0;
        #1;
        n_tests++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready_after got=%b exp=1", bus.b_ready); end
    endtask

    task automatic test_a_burst();
        logic [31:0] vals [2] = '{32'h11, 32'h22};
        bus.a_valid = 1; bus.a_reg = 5'd5;
        foreach (vals[i]) begin
            bus.a_data = vals[i];
            cycle();
            n_tests++; if (bus.rf_wr !== 1'b1 || bus.wr_reg !== 5'd5 || bus.wr_data !== vals[i]) begin
                n_fail++; $display("FAIL a_burst[%0d] got=%b/%0d/%h exp=1/5/%h", i, bus.rf_wr, bus.wr_reg, bus.wr_data, vals[i]);
            end
        end
        n_tests++; if (bus.b_ready !== 1'b1 || bus.fifo_count !== CW'(0)) begin
            n_fail++; $display("FAIL a_burst_fifo got=%b/%0d exp=1/0", bus.b_ready, bus.fifo_count);
        end
        idle_inputs();
    endtask

    task automatic test_b_push_pop();
        idle_inputs();
        bus.b_valid = 1; bus.b_reg = 5'd7; bus.b_data = 32'hDEAD_BEEF; bus.q_reg = 5'd7;
        #1;
        n_tests++; if (bus.q_pending !== 1'b0) begin n_fail++; $display("FAIL bpp_qp_before got=%b exp=0", bus.q_pending); end
        cycle();
        bus.b_valid = 0;
        n_tests++; if (bus.fifo_count !== CW'(1) || bus.rf_wr !== 1'b0) begin
            n_fail++; $display("FAIL bpp_push got=%0d/%b exp=1/0", bus.fifo_count, bus.rf_wr);
        end
        n_tests++; if (bus.q_pending !== 1'b1) begin n_fail++; $display("FAIL bpp_qp_queued got=%b exp=1", bus.q_pending); end
        cycle();
        n_tests++; if (bus.rf_wr !== 1'b1 || bus.wr_reg !== 5'd7 || bus.wr_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bpp_pop got=%b/%0d/%h exp=1/7/deadbeef", bus.rf_wr, bus.wr_reg, bus.wr_data);
        end
        n_tests++; if (bus.q_pending !== 1'b1 || bus.fifo_count !== CW'(0)) begin
            n_fail++; $display("FAIL bpp_qp_outreg got=%b/%0d exp=1/0", bus.q_pending, bus.fifo_count);
        end
        cycle();
        n_tests++; if (bus.rf_wr !== 1'b0 || bus.q_pending !== 1'b0) begin
            n_fail++; $display("FAIL bpp_after got=%b/%b exp=0/0", bus.rf_wr, bus.q_pending);
        end
    endtask

    task automatic test_starve();
        logic [31:0] bd [4];
        logic [31:0] ad;
        idle_inputs();
        bus.a_valid = 1; bus.a_reg = 5'd3; bus.b_valid = 1;
        for (int i = 0; i < STARVE_LIMIT + 4; i++) begin
            ad = $urandom; bus.a_data = ad;
            if (i < 4) begin bus.b_reg = 5'(10 + i); bd[i] = $urandom; bus.b_data = bd[i]; end
            else bus.b_valid = 0;
            cycle();
            n_tests++; if (bus.rf_wr !== 1'b1 || bus.wr_reg !== 5'd3 || bus.wr_data !== ad) begin
                n_fail++; $display("FAIL starve_a[%0d] got=%b/%0d/%h exp=1/3/%h", i, bus.rf_wr, bus.wr_reg, bus.wr_data, ad);
            end
            n_tests++; if (bus.stall_req !== (i >= STARVE_LIMIT + 1)) begin
                n_fail++; $display("FAIL starve_stall[%0d] got=%b exp=%b", i, bus.stall_req, (i >= STARVE_LIMIT + 1));
            end
            n_tests++; if (bus.fifo_count !== CW'((i < 3) ? i + 1 : 4)) begin
                n_fail++; $display("FAIL starve_count[%0d] got=%0d", i, bus.fifo_count);
            end
        end
        n_tests++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL starve_full_ready got=%b exp=0", bus.b_ready); end
        bus.a_valid = 0;
        for (int j = 0; j < 4; j++) begin
            cycle();
            n_tests++; if (bus.rf_wr !== 1'b1 || bus.wr_reg !== 5'(10 + j) || bus.wr_data !== bd[j]) begin
                n_fail++; $display("FAIL drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", j, bus.rf_wr, bus.wr_reg, bus.wr_data, 10 + j, bd[j]);
            end
            n_tests++; if (bus.stall_req !== 1'b0 || bus.fifo_count !== CW'(3 - j)) begin
                n_fail++; $display("FAIL drain_state[%0d] got=%b/%0d exp=0/%0d", j, bus.stall_req, bus.fifo_count, 3 - j);
            end
        end
        cycle();
        n_tests++; if (bus.rf_wr !== 1'b0) begin n_fail++; $display("FAIL drain_end got=%b exp=0", bus.rf_wr); end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1; bus.a_reg = 5'd0; bus.a_data = $urandom;
            bus.b_valid = 1; bus.b_reg = 5'd0; bus.b_data = $urandom;
            cycle();
            n_tests++; if (bus.rf_wr !== 1'b0 || bus.fifo_count !== CW'(0) || bus.b_ready !== 1'b1) begin
                n_fail++; $display("FAIL zero_reg[%0d] got=%b/%0d/%b exp=0/0/1", i, bus.rf_wr, bus.fifo_count, bus.b_ready);
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_wrap();
        idle_inputs();
        bus.a_valid = 1; bus.a_reg = 5'd1; bus.b_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.a_data = $urandom; bus.b_reg = 5'(20 + i); bus.b_data = 32'h100 + i;
            cycle();
        end
        n_tests++; if (bus.fifo_count !== CW'(DEPTH) || bus.b_ready !== 1'b0) begin
            n_fail++; $display("FAIL full got=%0d/%b exp=%0d/0", bus.fifo_count, bus.b_ready, DEPTH);
        end
        bus.a_valid = 0; bus.b_reg = 5'd21; bus.b_data = 32'hBAD;
        cycle();
        n_tests++; if (bus.rf_wr !== 1'b1 || bus.wr_reg !== 5'd20 || bus.wr_data !== 32'h100 || bus.fifo_count !== CW'(3)) begin
            n_fail++; $display("FAIL full_pop got=%b/%0d/%h/%0d exp=1/20/100/3", bus.rf_wr, bus.wr_reg, bus.wr_data, bus.fifo_count);
        end
        for (int k = 0; k < 3 * DEPTH; k++) begin
            bus.b_reg = 5'(1 + (k % 31)); bus.b_data = 32'h200 + k;
            cycle();
            n_tests++; if (bus.rf_wr !== m_wr || bus.wr_reg !== m_reg || bus.wr_data !== m_data || bus.fifo_count !== CW'(3)) begin
                n_fail++; $display("FAIL wrap[%0d] got=%b/%0d/%h/%0d exp=%b/%0d/%h/3", k, bus.rf_wr, bus.wr_reg, bus.wr_data, bus.fifo_count, m_wr, m_reg, m_data);
            end
        end
        bus.b_valid = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_tests++; if (bus.rf_wr !== m_wr || (m_wr && bus.wr_data !== m_data) || bus.fifo_count !== CW'(mq.size())) begin
                n_fail++; $display("FAIL wrap_drain[%0d] got=%b/%h/%0d exp=%b/%h/%0d", k, bus.rf_wr, bus.wr_data, bus.fifo_count, m_wr, m_data, mq.size());
            end
        end
        n_tests++; if (bus.wr_data !== 32'h200 + 3 * DEPTH - 1) begin
            n_fail++; $display("FAIL wrap_last got=%h exp=%h", bus.wr_data, 32'h200 + 3 * DEPTH - 1);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            bus.a_valid = ($urandom_range(0, 99) < 55);
            bus.a_reg   = 5'($urandom_range(0, 7));
            bus.a_data  = $urandom;
            bus.b_valid = ($urandom_range(0, 99) < 60);
            bus.b_reg   = 5'($urandom_range(0, 7));
            bus.b_data  = $urandom;
            bus.q_reg   = 5'($urandom_range(0, 7));
            #1;
            n_tests++; if (bus.b_ready !== m_b_ready() || bus.q_pending !== m_q_pending(bus.q_reg)) begin
                n_fail++; $display("FAIL rand_comb[%0d] got=%b/%b exp=%b/%b", i, bus.b_ready, bus.q_pending, m_b_ready(), m_q_pending(bus.q_reg));
            end
            cycle();
            n_tests++; if (bus.rf_wr !== m_wr || bus.wr_reg !== m_reg || bus.wr_data !== m_data) begin
                n_fail++; $display("FAIL rand_out[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, bus.rf_wr, bus.wr_reg, bus.wr_data, m_wr, m_reg, m_data);
            end
            n_tests++; if (bus.fifo_count !== CW'(mq.size()) || bus.stall_req !== m_stall) begin
                n_fail++; $display("FAIL rand_state[%0d] got=%0d/%b exp=%0d/%b", i, bus.fifo_count, bus.stall_req, mq.size(), m_stall);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        cycle(); cycle(); cycle(); cycle(); cycle();
        bus.a_valid = 1; bus.a_reg = 5'd2; bus.b_valid = 1;
        for (int i = 0; i < STARVE_LIMIT + 5; i++) begin
            bus.a_data = $urandom;
            if (i < 3) begin bus.b_reg = 5'(4 + i); bus.b_data = $urandom; end
            else bus.b_valid = 0;
            cycle();
        end
        n_tests++; if (bus.fifo_count !== CW'(3) || bus.stall_req !== 1'b1) begin
            n_fail++; $display("FAIL mrst_pre got=%0d/%b exp=3/1", bus.fifo_count, bus.stall_req);
        end
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        n_tests++; if (bus.fifo_count !== CW'(0) || bus.rf_wr !== 1'b0 || bus.stall_req !== 1'b0) begin
            n_fail++; $display("FAIL mrst_post got=%0d/%b/%b exp=0/0/0", bus.fifo_count, bus.rf_wr, bus.stall_req);
        end
        for (int q = 0; q < 32; q++) begin
            bus.q_reg = 5'(q);
            #1;
            n_tests++; if (bus.q_pending !== 1'b0) begin n_fail++; $display("FAIL mrst_qp[%0d] got=%b exp=0", q, bus.q_pending); end
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_tests++; if (bus.rf_wr !== 1'b0) begin n_fail++; $display("FAIL mrst_stale[%0d] got=%b exp=0", i, bus.rf_wr); end
        end
    endtask

    initial begin
        test_reset();
        test_a_burst();
        test_b_push_pop();
        test_starve();
        test_zero_reg();
        test_full_wrap();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
